// File: rtl/mra_arb_if.sv
// Bundle of requester-side and downstream-side signals for mra_arb.
// slave = the arbiter's view, master = the view of whatever surrounds it.
interface mra_arb_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int NUM_REQ    = 4,
    parameter int TAG_DEPTH  = 8
);
    logic [NUM_REQ*ADDR_WIDTH-1:0] R_req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] R_req_data;
    logic [NUM_REQ-1:0]            R_rw;
    logic [NUM_REQ-1:0]            R_req_valid;
    logic [NUM_REQ-1:0]            R_ready;
    logic [NUM_REQ-1:0]            R_rsp_valid;
    logic [DATA_WIDTH-1:0]         R_rsp_data;
    logic [ADDR_WIDTH-1:0]         MRA_req_addr;
    logic [DATA_WIDTH-1:0]         MRA_req_data;
    logic                          MRA_rw;
    logic                          MRA_req_valid;
    logic                          MRA_ready;
    logic [DATA_WIDTH-1:0]         MRA_rsp_data;
    logic                          MRA_rsp_valid;
    logic [$clog2(TAG_DEPTH):0]    outstanding;
    logic                          rsp_err;

    modport slave (
        input  R_req_addr, R_req_data, R_rw, R_req_valid,
        input  MRA_ready, MRA_rsp_data, MRA_rsp_valid,
        output R_ready, R_rsp_valid, R_rsp_data,
        output MRA_req_addr, MRA_req_data, MRA_rw, MRA_req_valid,
        output outstanding, rsp_err
    );

    modport master (
        output R_req_addr, R_req_data, R_rw, R_req_valid,
        output MRA_ready, MRA_rsp_data, MRA_rsp_valid,
        input  R_ready, R_rsp_valid, R_rsp_data,
        input  MRA_req_addr, MRA_req_data, MRA_rw, MRA_req_valid,
        input  outstanding, rsp_err
    );
endinterface

// File: rtl/mra_arb.sv
// Round-robin N:1 memory request arbiter with a one-entry output slot and an
// in-order read-ID FIFO that routes downstream responses back to requesters.
module mra_arb #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int NUM_REQ    = 4,
    parameter int TAG_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       rst,
    mra_arb_if.slave   bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    logic                  r_slot_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_rw;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_ids [TAG_DEPTH];
    logic [PW-1:0]         r_wp;
    logic [PW-1:0]         r_rp;
    logic [CW-1:0]         r_cnt;
    logic                  r_err;

    logic                  w_slot_free;
    logic                  w_rd_ok;
    logic [NUM_REQ-1:0]    w_elig;
    logic                  w_any;
    logic [IW-1:0]         w_win;
    int unsigned           w_idx;
    logic                  w_grant;
    logic                  w_push;
    logic                  w_pop;

    assign w_slot_free = !r_slot_valid || bus.MRA_ready;
    // Admission uses the pre-pop count, so a full FIFO blocks reads even on a pop cycle.
    assign w_rd_ok     = r_cnt < CW'(TAG_DEPTH);
    assign w_elig      = bus.R_req_valid & (bus.R_rw | {NUM_REQ{w_rd_ok}});

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_any && w_elig[IW'(w_idx)]) begin
                w_any = 1'b1;
                w_win = IW'(w_idx);
            end
        end
    end

    assign w_grant = rst && w_slot_free && w_any;
    assign w_push  = w_grant && !bus.R_rw[w_win];
    assign w_pop   = rst && bus.MRA_rsp_valid && (r_cnt != '0);

    always_comb begin
        bus.R_ready     = '0;
        bus.R_rsp_valid = '0;
        if (w_grant) bus.R_ready[w_win] = 1'b1;
        if (w_pop)   bus.R_rsp_valid[r_ids[r_rp]] = 1'b1;
    end

    assign bus.R_rsp_data    = bus.MRA_rsp_data;
    assign bus.MRA_req_addr  = r_addr;
    assign bus.MRA_req_data  = r_data;
    assign bus.MRA_rw        = r_rw;
    assign bus.MRA_req_valid = r_slot_valid;
    assign bus.outstanding   = r_cnt;
    assign bus.rsp_err       = r_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_slot_valid <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_rw         <= 1'b0;
            r_ptr        <= '0;
            r_wp         <= '0;
            r_rp         <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_grant) begin
                r_slot_valid <= 1'b1;
                r_addr       <= bus.R_req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
                r_data       <= bus.R_req_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                r_rw         <= bus.R_rw[w_win];
                r_ptr        <= (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
            end else if (bus.MRA_ready) begin
                r_slot_valid <= 1'b0;
            end

            if (w_push) begin
                r_ids[r_wp] <= w_win;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase

            if (bus.MRA_rsp_valid && r_cnt == '0) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mra_arb.sv
// Directed bench for mra_arb: arbitration order, stall hold, read admission,
// response routing, error flag and reset behaviour.
module tb_mra_arb;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int NR = 4;
    localparam int TD = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mra_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TAG_DEPTH(TD)) bus ();

    mra_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TAG_DEPTH(TD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int unsigned i, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.R_req_valid[i]        = v;
        bus.R_rw[i]               = w;
        bus.R_req_addr[i*AW +: AW] = a;
        bus.R_req_data[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        for (int unsigned i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(64'h10 + i), DW'(i));
        bus.MRA_ready     = 1'b1;
        bus.MRA_rsp_valid = 1'b1;
        bus.MRA_rsp_data  = DW'(64'hBAD);
        tick();
        tick();
        n_checks++; if (bus.MRA_req_valid !== 1'b0) begin n_errors++; $display("FAIL rst_req_valid: got %b expected 0", bus.MRA_req_valid); end
        n_checks++; if (bus.outstanding !== 4'd0) begin n_errors++; $display("FAIL rst_outstanding: got %0d expected 0", bus.outstanding); end
        n_checks++; if (bus.rsp_err !== 1'b0) begin n_errors++; $display("FAIL rst_rsp_err: got %b expected 0", bus.rsp_err); end
        n_checks++; if (bus.MRA_req_addr !== 64'h0) begin n_errors++; $display("FAIL rst_addr: got %h expected 0", bus.MRA_req_addr); end
        n_checks++; if (bus.MRA_rw !== 1'b0) begin n_errors++; $display("FAIL rst_rw: got %b expected 0", bus.MRA_rw); end
        n_checks++; if (bus.R_ready !== 4'b0000) begin n_errors++; $display("FAIL rst_R_ready: got %b expected 0000", bus.R_ready); end
        n_checks++; if (bus.R_rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL rst_R_rsp_valid: got %b expected 0000", bus.R_rsp_valid); end
        for (int unsigned i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, '0, '0);
        bus.MRA_rsp_valid = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    // Leaves the round-robin pointer at 2.
    task automatic test_round_robin();
        logic [NR-1:0] e;
        for (int unsigned i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(64'h1000 + i), DW'(64'hA0 + i));
        bus.MRA_ready = 1'b1;
        #1;
        n_checks++; if (bus.MRA_req_valid !== 1'b0) begin n_errors++; $display("FAIL rr_pre_valid: got %b expected 0", bus.MRA_req_valid); end
        for (int k = 0; k < 6; k++) begin
            e = 4'(1 << (k % 4));
            n_checks++; if (bus.R_ready !== e) begin n_errors++; $display("FAIL rr_ready k=%0d: got %b expected %b", k, bus.R_ready, e); end
            tick();
            n_checks++; if (bus.MRA_req_valid !== 1'b1) begin n_errors++; $display("FAIL rr_valid k=%0d: got %b expected 1", k, bus.MRA_req_valid); end
            n_checks++; if (bus.MRA_req_addr !== AW'(64'h1000 + k % 4)) begin n_errors++; $display("FAIL rr_addr k=%0d: got %h expected %h", k, bus.MRA_req_addr, 64'h1000 + k % 4); end
            n_checks++; if (bus.MRA_req_data !== DW'(64'hA0 + k % 4)) begin n_errors++; $display("FAIL rr_data k=%0d: got %h", k, bus.MRA_req_data[63:0]); end
            n_checks++; if (bus.outstanding !== 4'(k + 1)) begin n_errors++; $display("FAIL rr_outstanding k=%0d: got %0d expected %0d", k, bus.outstanding, k + 1); end
        end
        for (int unsigned i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, '0, '0);
        tick();
        n_checks++; if (bus.MRA_req_valid !== 1'b0) begin n_errors++; $display("FAIL rr_drain: got %b expected 0", bus.MRA_req_valid); end
        for (int j = 0; j < 6; j++) begin
            bus.MRA_rsp_valid = 1'b1;
            bus.MRA_rsp_data  = DW'(64'hD000 + j);
            #1;
            e = 4'(1 << (j % 4));
            n_checks++; if (bus.R_rsp_valid !== e) begin n_errors++; $display("FAIL rr_rsp_valid j=%0d: got %b expected %b", j, bus.R_rsp_valid, e); end
            n_checks++; if (bus.R_rsp_data !== DW'(64'hD000 + j)) begin n_errors++; $display("FAIL rr_rsp_data j=%0d: got %h expected %h", j, bus.R_rsp_data[63:0], 64'hD000 + j); end
            tick();
            n_checks++; if (bus.outstanding !== 4'(5 - j)) begin n_errors++; $display("FAIL rr_pop_count j=%0d: got %0d expected %0d", j, bus.outstanding, 5 - j); end
        end
        bus.MRA_rsp_valid = 1'b0;
    endtask

    // Pointer at 2 on entry, 3 on exit.
    task automatic test_stall();
        bus.MRA_ready = 1'b0;
        set_req(2, 1'b1, 1'b1, 64'h40, DW'(64'h4444));
        #1;
        n_checks++; if (bus.R_ready !== 4'b0100) begin n_errors++; $display("FAIL st_grant: got %b expected 0100", bus.R_ready); end
        tick();
        set_req(2, 1'b1, 1'b1, 64'h80, DW'(64'h8888));
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (bus.R_ready !== 4'b0000) begin n_errors++; $display("FAIL st_ready c=%0d: got %b expected 0000", c, bus.R_ready); end
            n_checks++; if (bus.MRA_req_addr !== 64'h40 || bus.MRA_rw !== 1'b1 || bus.MRA_req_valid !== 1'b1) begin n_errors++; $display("FAIL st_hold c=%0d: got addr %h rw %b valid %b expected 40 1 1", c, bus.MRA_req_addr, bus.MRA_rw, bus.MRA_req_valid); end
            tick();
        end
        bus.MRA_ready = 1'b1;
        #1;
        n_checks++; if (bus.MRA_req_addr !== 64'h40 || bus.MRA_req_data !== DW'(64'h4444)) begin n_errors++; $display("FAIL st_hold4: got %h expected 40", bus.MRA_req_addr); end
        n_checks++; if (bus.R_ready !== 4'b0100) begin n_errors++; $display("FAIL st_drain_grant: got %b expected 0100", bus.R_ready); end
        tick();
        n_checks++; if (bus.MRA_req_addr !== 64'h80) begin n_errors++; $display("FAIL st_next: got %h expected 80", bus.MRA_req_addr); end
        set_req(2, 1'b0, 1'b0, '0, '0);
        tick();
        n_checks++; if (bus.MRA_req_valid !== 1'b0 || bus.outstanding !== 4'd0) begin n_errors++; $display("FAIL st_end: got valid %b outstanding %0d expected 0 0", bus.MRA_req_valid, bus.outstanding); end
    endtask

    // Pointer at 3 on entry, 1 on exit.
    task automatic test_full();
        bus.MRA_ready = 1'b1;
        set_req(0, 1'b1, 1'b0, 64'h2000, DW'(64'h2));
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++; if (bus.R_ready !== 4'b0001) begin n_errors++; $display("FAIL full_fill k=%0d: got %b expected 0001", k, bus.R_ready); end
            tick();
        end
        n_checks++; if (bus.outstanding !== 4'd8) begin n_errors++; $display("FAIL full_count: got %0d expected 8", bus.outstanding); end
        n_checks++; if (bus.R_ready !== 4'b0000) begin n_errors++; $display("FAIL full_block: got %b expected 0000", bus.R_ready); end
        set_req(1, 1'b1, 1'b1, 64'h3000, DW'(64'h3));
        #1;
        n_checks++; if (bus.R_ready !== 4'b0010) begin n_errors++; $display("FAIL full_write: got %b expected 0010", bus.R_ready); end
        tick();
        n_checks++; if (bus.MRA_rw !== 1'b1 || bus.MRA_req_addr !== 64'h3000 || bus.outstanding !== 4'd8) begin n_errors++; $display("FAIL full_write_slot: got rw %b addr %h count %0d expected 1 3000 8", bus.MRA_rw, bus.MRA_req_addr, bus.outstanding); end
        set_req(1, 1'b0, 1'b0, '0, '0);
        bus.MRA_rsp_valid = 1'b1;
        bus.MRA_rsp_data  = DW'(64'h55);
        #1;
        n_checks++; if (bus.R_ready !== 4'b0000 || bus.R_rsp_valid !== 4'b0001) begin n_errors++; $display("FAIL full_pop_block: got ready %b rsp %b expected 0000 0001", bus.R_ready, bus.R_rsp_valid); end
        tick();
        n_checks++; if (bus.outstanding !== 4'd7) begin n_errors++; $display("FAIL full_pop_count: got %0d expected 7", bus.outstanding); end
        n_checks++; if (bus.R_ready !== 4'b0001 || bus.R_rsp_valid !== 4'b0001) begin n_errors++; $display("FAIL full_edge_admit: got ready %b rsp %b expected 0001 0001", bus.R_ready, bus.R_rsp_valid); end
        tick();
        n_checks++; if (bus.outstanding !== 4'd7) begin n_errors++; $display("FAIL full_pushpop: got %0d expected 7", bus.outstanding); end
        set_req(0, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 7; k++) tick();
        bus.MRA_rsp_valid = 1'b0;
        n_checks++; if (bus.outstanding !== 4'd0 || bus.rsp_err !== 1'b0) begin n_errors++; $display("FAIL full_drain: got count %0d err %b expected 0 0", bus.outstanding, bus.rsp_err); end
    endtask

    // Pointer at 1 on entry, 0 on exit.
    task automatic test_order();
        logic [NR-1:0] ids [3];
        ids[0] = 4'b1000; ids[1] = 4'b0010; ids[2] = 4'b1000;
        bus.MRA_ready = 1'b1;
        set_req(3, 1'b1, 1'b0, 64'h3300, '0);
        #1;
        n_checks++; if (bus.R_ready !== 4'b1000) begin n_errors++; $display("FAIL ord_g0: got %b expected 1000", bus.R_ready); end
        tick();
        set_req(3, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b1, 1'b0, 64'h1100, '0);
        #1;
        n_checks++; if (bus.R_ready !== 4'b0010) begin n_errors++; $display("FAIL ord_g1: got %b expected 0010", bus.R_ready); end
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0);
        set_req(3, 1'b1, 1'b0, 64'h3301, '0);
        #1;
        n_checks++; if (bus.R_ready !== 4'b1000) begin n_errors++; $display("FAIL ord_g2: got %b expected 1000", bus.R_ready); end
        tick();
        set_req(3, 1'b0, 1'b0, '0, '0);
        tick();
        n_checks++; if (bus.outstanding !== 4'd3) begin n_errors++; $display("FAIL ord_count: got %0d expected 3", bus.outstanding); end
        for (int j = 0; j < 3; j++) begin
            bus.MRA_rsp_valid = 1'b1;
            bus.MRA_rsp_data  = DW'(64'hC0DE0 + j);
            #1;
            n_checks++; if (bus.R_rsp_valid !== ids[j] || bus.R_rsp_data !== DW'(64'hC0DE0 + j)) begin n_errors++; $display("FAIL ord_rsp j=%0d: got %b/%h expected %b/%h", j, bus.R_rsp_valid, bus.R_rsp_data[63:0], ids[j], 64'hC0DE0 + j); end
            tick();
        end
        bus.MRA_rsp_valid = 1'b0;
        n_checks++; if (bus.outstanding !== 4'd0) begin n_errors++; $display("FAIL ord_end: got %0d expected 0", bus.outstanding); end
    endtask

    task automatic test_rsp_err();
        bus.MRA_rsp_valid = 1'b1;
        bus.MRA_rsp_data  = DW'(64'hEE);
        #1;
        n_checks++; if (bus.R_rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL err_no_rsp: got %b expected 0000", bus.R_rsp_valid); end
        tick();
        bus.MRA_rsp_valid = 1'b0;
        n_checks++; if (bus.rsp_err !== 1'b1 || bus.outstanding !== 4'd0) begin n_errors++; $display("FAIL err_set: got err %b count %0d expected 1 0", bus.rsp_err, bus.outstanding); end
        tick();
        tick();
        n_checks++; if (bus.rsp_err !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %b expected 1", bus.rsp_err); end
    endtask

    // Pointer at 0 on entry; three grants move it to 3 before reset.
    task automatic test_reset_mid();
        bus.MRA_ready = 1'b1;
        for (int unsigned i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, AW'(64'h500 + i), '0);
        tick();
        tick();
        tick();
        n_checks++; if (bus.outstanding !== 4'd3 || bus.MRA_req_valid !== 1'b1) begin n_errors++; $display("FAIL rm_pre: got count %0d valid %b expected 3 1", bus.outstanding, bus.MRA_req_valid); end
        for (int unsigned i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, '0, '0);
        bus.MRA_ready = 1'b0;
        rst = 1'b0;
        tick();
        n_checks++; if (bus.MRA_req_valid !== 1'b0 || bus.outstanding !== 4'd0 || bus.rsp_err !== 1'b0) begin n_errors++; $display("FAIL rm_state: got valid %b count %0d err %b expected 0 0 0", bus.MRA_req_valid, bus.outstanding, bus.rsp_err); end
        n_checks++; if (bus.MRA_req_addr !== 64'h0) begin n_errors++; $display("FAIL rm_addr: got %h expected 0", bus.MRA_req_addr); end
        rst = 1'b1;
        tick();
        bus.MRA_rsp_valid = 1'b1;
        #1;
        n_checks++; if (bus.R_rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL rm_stale_rsp: got %b expected 0000", bus.R_rsp_valid); end
        tick();
        bus.MRA_rsp_valid = 1'b0;
        n_checks++; if (bus.rsp_err !== 1'b1) begin n_errors++; $display("FAIL rm_err: got %b expected 1", bus.rsp_err); end
        bus.MRA_ready = 1'b1;
        for (int unsigned i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(64'h600 + i), '0);
        #1;
        n_checks++; if (bus.R_ready !== 4'b0001) begin n_errors++; $display("FAIL rm_ptr: got %b expected 0001", bus.R_ready); end
        tick();
        for (int unsigned i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    initial begin
        bus.R_req_addr    = '0;
        bus.R_req_data    = '0;
        bus.R_rw          = '0;
        bus.R_req_valid   = '0;
        bus.MRA_ready     = 1'b0;
        bus.MRA_rsp_data  = '0;
        bus.MRA_rsp_valid = 1'b0;
        test_reset();
        test_round_robin();
        test_stall();
        test_full();
        test_order();
        test_rsp_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mra_arb.md
MRA_ARB -- requirements
Module: mra_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, memory address width.
REQ-002 Parameter DATA_WIDTH, default 512, memory data width.
REQ-003 Parameter NUM_REQ, default 4, number of requesters; legal range 2..8.
REQ-004 Parameter TAG_DEPTH, default 8, maximum outstanding reads; power of two.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 R_req_addr  input  NUM_REQ*ADDR_WIDTH  per-requester address; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 R_req_data  input  NUM_REQ*DATA_WIDTH  per-requester write data, same slicing.
REQ-009 R_rw  input  NUM_REQ  per-requester direction: 1=write, 0=read.
REQ-010 R_req_valid  input  NUM_REQ  per-requester request valid.
REQ-011 R_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-012 R_rsp_valid  output  NUM_REQ  per-requester read-response strobe; one-hot or zero.
REQ-013 R_rsp_data  output  DATA_WIDTH  read data broadcast to all requesters.
REQ-014 MRA_req_addr, MRA_req_data, MRA_rw  output  ADDR_WIDTH, DATA_WIDTH, 1  downstream request fields.
REQ-015 MRA_req_valid  output  1  downstream request valid.
REQ-016 MRA_ready  input  1  downstream accept.
REQ-017 MRA_rsp_data, MRA_rsp_valid  input  DATA_WIDTH, 1  in-order read response from downstream.
REQ-018 outstanding  output  $clog2(TAG_DEPTH)+1  count of reads issued but not yet answered.
REQ-019 rsp_err  output  1  sticky: a response arrived while outstanding==0.

Function
REQ-020 A one-entry output register (slot) holds the request presented on the MRA_* outputs; MRA_req_valid is 1 exactly when the slot is full.
REQ-021 The slot SHALL drain when MRA_req_valid and MRA_ready are both 1; fields SHALL remain stable while the slot is full and not draining.
REQ-022 The slot can accept a request when it is empty or draining this cycle (slot_free).
REQ-023 Read admission: a read may be granted only if outstanding < TAG_DEPTH; otherwise that requester is masked this cycle; writes are never masked.
REQ-024 Round-robin arbitration among eligible requesters (valid and not masked); search starts at index ptr and proceeds upward, wrapping at NUM_REQ-1 to 0.
REQ-025 When slot_free and an eligible requester exists, R_ready of the winner SHALL be 1 in the same cycle (combinational); the request is loaded into the slot on that edge.
REQ-026 On a grant to requester g, ptr <= (g+1) mod NUM_REQ; with no grant, ptr holds.
REQ-027 No grant when slot not free; all R_ready SHALL be 0.
REQ-028 Latency: request accepted at edge N is on MRA_* outputs from cycle N+1; back-to-back accepts occur every cycle while MRA_ready=1.
REQ-029 Each granted read pushes its requester index into a TAG_DEPTH-entry ID FIFO at grant time; writes push nothing.
REQ-030 On MRA_rsp_valid with FIFO non-empty: pop the head ID h; R_rsp_valid[h]=1 in the same cycle; R_rsp_data=MRA_rsp_data combinationally.
REQ-031 outstanding = FIFO occupancy; simultaneous push and pop leave it unchanged; push and pop pointers wrap modulo TAG_DEPTH.
REQ-032 On MRA_rsp_valid with FIFO empty: no R_rsp_valid asserted, rsp_err set to 1, and it holds until reset; FIFO unchanged.
REQ-033 A read at outstanding==TAG_DEPTH-1 coinciding with a response pop is admitted, since the admission check uses the current-cycle value before the pop.

Reset
REQ-034 When rst=0 at a clock edge: slot empty, MRA_req_valid=0, ptr=0, FIFO empty, outstanding=0, rsp_err=0; R_ready and R_rsp_valid SHALL be 0 while rst=0.
REQ-035 Reset asserted mid-operation discards the slot contents and all outstanding IDs; responses arriving after reset release set rsp_err.
REQ-036 MRA_req_addr, MRA_req_data and MRA_rw reset to 0.

Verification
REQ-037 All four requesters issue reads every cycle, MRA_ready=1 -> grants go 0,1,2,3,0,..., one per cycle; MRA_req_valid first rises one cycle after the first grant.
REQ-038 Requester 2 issues a write to 0x40 while MRA_ready=0 for 3 cycles -> MRA_req_addr=0x40 stable for 4 cycles; no R_ready asserted until the drain cycle.
REQ-039 Eight reads issued with no responses -> outstanding=8; a further read is blocked (R_ready=0) while a concurrent write from another requester is still granted.
REQ-040 Reads from requesters 3,1,3 followed by three responses D0,D1,D2 -> R_rsp_valid pulses on 3,1,3, with R_rsp_data = D0,D1,D2 respectively.
REQ-041 MRA_rsp_valid=1 with outstanding=0 -> rsp_err=1, no R_rsp_valid; rsp_err clears only on reset.
REQ-042 rst driven low with 3 reads outstanding and the slot full -> next cycle MRA_req_valid=0, outstanding=0, and the round-robin pointer restarts at requester 0.
